// File: rtl/level_meter.sv
// Level meter: synchronises and debounces N_LEVELS inputs, registers their popcount,
// and keeps a peak-hold value that holds, then decays one step at a time toward the count.
module level_meter #(
    parameter int unsigned N_LEVELS     = 6,
    parameter int unsigned DEBOUNCE     = 4,
    parameter int unsigned HOLD_CYCLES  = 16,
    parameter int unsigned DECAY_CYCLES = 8,
    localparam int unsigned CW = $clog2(N_LEVELS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_LEVELS-1:0] levels,
    input  logic                peak_clr,
    output logic [CW-1:0]       count,
    output logic [CW-1:0]       peak,
    output logic                changed,
    output logic                full,
    output logic                empty
);

    localparam int unsigned DW  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int unsigned HW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned DCW = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;

    typedef enum logic [1:0] {StTrack, StHold, StDecay} state_e;

    logic [N_LEVELS-1:0] s1, s2, stable;
    logic [DW-1:0]       db_cnt [N_LEVELS];
    logic [CW-1:0]       ones;
    logic [CW-1:0]       count_q, peak_q, peak_d;
    logic                changed_q, full_q, empty_q;
    logic [HW-1:0]       hold_q, hold_d;
    logic [DCW-1:0]      decay_q, decay_d;
    state_e              state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= levels;
            s2 <= s1;
        end
    end

    // A bit flips only after DEBOUNCE consecutive cycles of disagreement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= '0;
            for (int i = 0; i < N_LEVELS; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_LEVELS; i++) begin
                if (s2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE - 1)) begin
                    stable[i] <= s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    always_comb begin
        ones = '0;
        for (int i = 0; i < N_LEVELS; i++) ones = ones + CW'(stable[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            changed_q <= 1'b0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
        end else begin
            count_q   <= ones;
            changed_q <= (ones != count_q);
            full_q    <= (ones == CW'(N_LEVELS));
            empty_q   <= (ones == '0);
        end
    end

    always_comb begin
        state_d = state_q;
        peak_d  = peak_q;
        hold_d  = hold_q;
        decay_d = decay_q;
        if (peak_clr || (count_q > peak_q)) begin
            peak_d  = count_q;
            state_d = StTrack;
        end else begin
            case (state_q)
                StTrack: begin
                    if (count_q < peak_q) begin
                        hold_d  = HW'(HOLD_CYCLES - 1);
                        state_d = StHold;
                    end
                end
                StHold: begin
                    if (hold_q == '0) begin
                        decay_d = DCW'(DECAY_CYCLES - 1);
                        state_d = StDecay;
                    end else begin
                        hold_d = hold_q - HW'(1);
                    end
                end
                StDecay: begin
                    if (count_q == peak_q) begin
                        state_d = StTrack;
                    end else if (decay_q == '0) begin
                        peak_d  = peak_q - CW'(1);
                        decay_d = DCW'(DECAY_CYCLES - 1);
                        if (peak_d == count_q) state_d = StTrack;
                    end else begin
                        decay_d = decay_q - DCW'(1);
                    end
                end
                default: state_d = StTrack;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StTrack;
            peak_q  <= '0;
            hold_q  <= '0;
            decay_q <= '0;
        end else begin
            state_q <= state_d;
            peak_q  <= peak_d;
            hold_q  <= hold_d;
            decay_q <= decay_d;
        end
    end

    assign count   = count_q;
    assign peak    = peak_q;
    assign changed = changed_q;
    assign full    = full_q;
    assign empty   = empty_q;

endmodule

// File: tb/tb_level_meter.sv
// Bench for level_meter: timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_level_meter;

    localparam int N     = 6;
    localparam int DEB   = 4;
    localparam int HOLD  = 16;
    localparam int DECAY = 8;
    localparam int CW    = $clog2(N + 1);

    logic          clk;
    logic          rst;
    logic [N-1:0]  levels;
    logic          peak_clr;
    logic [CW-1:0] count;
    logic [CW-1:0] peak;
    logic          changed;
    logic          full;
    logic          empty;

    int checks   = 0;
    int failures = 0;

    level_meter #(
        .N_LEVELS    (N),
        .DEBOUNCE    (DEB),
        .HOLD_CYCLES (HOLD),
        .DECAY_CYCLES(DECAY)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .levels  (levels),
        .peak_clr(peak_clr),
        .count   (count),
        .peak    (peak),
        .changed (changed),
        .full    (full),
        .empty   (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model. Debounce uses the edge index of the last agreement; peak hold
    // and decay use absolute edge deadlines instead of down-counters.
    logic [N-1:0] m_s1, m_s2, m_stable;
    int           m_last_ok [N];
    int           m_edge, m_count, m_peak, m_mode, m_evt;
    logic         m_changed;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1      <= '0;
            m_s2      <= '0;
            m_stable  <= '0;
            for (int i = 0; i < N; i++) m_last_ok[i] <= 0;
            m_edge    <= 0;
            m_count   <= 0;
            m_peak    <= 0;
            m_mode    <= 0;
            m_evt     <= 0;
            m_changed <= 1'b0;
        end else begin
            m_edge <= m_edge + 1;
            m_s1   <= levels;
            m_s2   <= m_s1;
            for (int i = 0; i < N; i++) begin
                if (m_s2[i] == m_stable[i]) begin
                    m_last_ok[i] <= m_edge + 1;
                end else if (m_edge + 1 - m_last_ok[i] >= DEB) begin
                    m_stable[i]  <= m_s2[i];
                    m_last_ok[i] <= m_edge + 1;
                end
            end
            m_count   <= $countones(m_stable);
            m_changed <= ($countones(m_stable) != m_count);
            if (peak_clr || m_count > m_peak) begin
                m_peak <= m_count;
                m_mode <= 0;
            end else if (m_mode == 0) begin
                if (m_count < m_peak) begin
                    m_mode <= 1;
                    m_evt  <= m_edge + 1 + HOLD;
                end
            end else if (m_mode == 1) begin
                if (m_edge + 1 == m_evt) begin
                    m_mode <= 2;
                    m_evt  <= m_edge + 1 + DECAY;
                end
            end else begin
                if (m_count == m_peak) begin
                    m_mode <= 0;
                end else if (m_edge + 1 == m_evt) begin
                    m_peak <= m_peak - 1;
                    m_evt  <= m_edge + 1 + DECAY;
                    if (m_peak - 1 == m_count) m_mode <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("count", int'(count), m_count);
        check("peak", int'(peak), m_peak);
        check("changed", int'(changed), int'(m_changed));
        check("full", int'(full), int'(m_count == N));
        check("empty", int'(empty), int'(m_count == 0));
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] r32;
        int          idx;
        rst      = 1'b1;
        levels   = '0;
        peak_clr = 1'b0;
        step(2);
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        rst    = 1'b0;
        levels = 6'b000111;

        // Input-to-count latency: count at edge 7, peak at edge 8.
        step(6);
        check("lat_count_e6", int'(count), 0);
        step(1);
        check("lat_count_e7", int'(count), 3);
        check("lat_changed_e7", int'(changed), 1);
        check("lat_full", int'(full), 0);
        check("lat_empty", int'(empty), 0);
        check("lat_peak_e7", int'(peak), 0);
        step(1);
        check("lat_peak_e8", int'(peak), 3);
        check("lat_changed_e8", int'(changed), 0);

        // Three-cycle glitch must not pass the debouncer.
        levels[0] = 1'b0;
        step(3);
        levels[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            check("glitch_changed", int'(changed), 0);
        end
        check("glitch_count", int'(count), 3);

        // Hold then decay from 6 down to 2.
        levels = '1;
        step(9);
        check("full_count", int'(count), 6);
        check("full_flag", int'(full), 1);
        check("full_peak", int'(peak), 6);
        levels = 6'b000011;
        step(7);
        check("drop_count", int'(count), 2);
        step(24);
        check("hold_peak", int'(peak), 6);
        step(1);
        check("decay_5", int'(peak), 5);
        step(8);
        check("decay_4", int'(peak), 4);
        step(8);
        check("decay_3", int'(peak), 3);
        step(8);
        check("decay_2", int'(peak), 2);
        step(10);
        check("decay_stop", int'(peak), 2);

        // Count rising into a decaying peak.
        levels = '1;
        step(9);
        levels = 6'b000011;
        step(7);
        step(33);
        check("rise_peak4", int'(peak), 4);
        levels = 6'b011111;
        step(7);
        check("rise_count5", int'(count), 5);
        check("rise_peak_lag", int'(peak), 4);
        step(1);
        check("rise_peak5", int'(peak), 5);
        step(20);
        check("rise_hold5", int'(peak), 5);

        // peak_clr while holding.
        levels = '1;
        step(9);
        levels = 6'b000011;
        step(12);
        check("clr_before", int'(peak), 6);
        peak_clr = 1'b1;
        step(1);
        peak_clr = 1'b0;
        check("clr_after", int'(peak), 2);
        step(30);
        check("clr_stays", int'(peak), 2);

        // Asynchronous reset in the middle of decay.
        levels = '1;
        step(9);
        levels = 6'b000011;
        step(27);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", int'(count), 0);
        check("arst_peak", int'(peak), 0);
        check("arst_empty", int'(empty), 1);
        check("arst_changed", int'(changed), 0);
        check("arst_full", int'(full), 0);
        #1;
        rst = 1'b0;
        step(20);
        check("arst_resume", int'(count), 2);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            step(1);
            idx = $urandom_range(0, 99);
            if (idx < 3) begin
                r32    = $urandom;
                levels = r32[N-1:0];
            end else if (idx < 9) begin
                idx         = $urandom_range(0, N - 1);
                levels[idx] = ~levels[idx];
            end
            peak_clr = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 999) < 2) begin
                #2;
                rst = 1'b1;
                #1;
                rst = 1'b0;
            end
        end
        peak_clr = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
